muldiv_sequencer: RTL and testbench

//  Multi-cycle RV32M multiply/divide unit and its sequencing FSM, sitting beside the ALU in EX.

---
 rtl/muldiv_sequencer.sv | 144 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide unit: one radix-2 shift-add or restoring-divide step per cycle,
// fixed WIDTH+1 cycle latency from accept to done, registered result held until the next done.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] Result
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2:0]         op_q, op_d;
   logic               sgn_a_q, sgn_a_d, sgn_b_q, sgn_b_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc_q, acc_d;       // product; for divide the low half shifts dividend out, quotient in
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   res_q, res_d;

   function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   logic             a_signed, b_signed, in_sgn_a, in_sgn_b;
   logic [WIDTH-1:0] mag_a, mag_b;

   always_comb begin
      a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
      b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
      in_sgn_a = a_signed & SrcA[WIDTH-1];
      in_sgn_b = b_signed & SrcB[WIDTH-1];
      mag_a    = cneg_w(SrcA, in_sgn_a);
      mag_b    = cneg_w(SrcB, in_sgn_b);
   end

   logic [WIDTH:0]     mul_sum, div_shift;
   logic [2*WIDTH-1:0] mul_next, prod;
   logic [WIDTH-1:0]   div_diff, div_rem_next, div_quo_next, fin;
   logic               div_ok;

   always_comb begin
      mul_sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next     = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift    = {rem_q, acc_q[WIDTH-1]};
      div_ok       = (div_shift >= {1'b0, opnd_q});
      div_diff     = div_shift[WIDTH-1:0] - opnd_q;
      div_rem_next = div_ok ? div_diff : div_shift[WIDTH-1:0];
      div_quo_next = {acc_q[WIDTH-2:0], div_ok};
      prod         = cneg_2w(mul_next, sgn_a_q ^ sgn_b_q);
      // Zero divisor needs an override only for the quotient; the remainder path already yields SrcA.
      case (op_q)
         3'b000:                 fin = prod[WIDTH-1:0];
         3'b001, 3'b010, 3'b011: fin = prod[2*WIDTH-1:WIDTH];
         3'b100, 3'b101:         fin = (opnd_q == '0) ? '1 : cneg_w(div_quo_next, sgn_a_q ^ sgn_b_q);
         default:                fin = cneg_w(div_rem_next, sgn_a_q);
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      sgn_a_d = sgn_a_q;
      sgn_b_d = sgn_b_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               state_d = S_BUSY;
               cnt_d   = CW'(WIDTH - 1);
               op_d    = Funct3;
               sgn_a_d = in_sgn_a;
               sgn_b_d = in_sgn_b;
               opnd_d  = Funct3[2] ? mag_b : mag_a;
               acc_d   = {{WIDTH{1'b0}}, (Funct3[2] ? mag_a : mag_b)};
               rem_d   = '0;
            end
         end
         S_BUSY: begin
            acc_d = op_q[2] ? {acc_q[2*WIDTH-1:WIDTH], div_quo_next} : mul_next;
            rem_d = op_q[2] ? div_rem_next : rem_q;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_DONE;
               cnt_d   = '0;
               res_d   = fin;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
         res_d   = res_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         sgn_a_q <= 1'b0;
         sgn_b_q <= 1'b0;
         opnd_q  <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         sgn_a_q <= sgn_a_d;
         sgn_b_q <= sgn_b_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         res_q   <= res_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign stall  = ((state_q == S_IDLE) && start && !flush) || (state_q == S_BUSY);
   assign done   = (state_q == S_DONE);
   assign Result = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer (WIDTH=32): directed vector table, flush/reset sequences,
// and random operations compared with an arithmetic reference model.
module tb_muldiv_sequencer;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset, start, flush;
   logic [2:0]    Funct3;
   logic [W-1:0]  SrcA, SrcB, Result;
   logic          busy, stall, done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .flush(flush), .Funct3(Funct3),
      .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .stall(stall), .done(done), .Result(Result)
   );

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0]        ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * $signed(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin if (b == '0) return '1; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == '0) return '1; return a / b; end
         3'd6: begin if (b == '0) return a; p = sa % sb; return p[31:0]; end
         default: begin if (b == '0) return a; return a % b; end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 15));
         default: return 32'($urandom());
      endcase
   endfunction

   // Entered just after a rising edge with the DUT idle; returns just after a rising edge, idle again.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int done_cyc, output bit tim_ok);
      Funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
      res = 'x;
      @(negedge clk);
      tim_ok = (stall === 1'b1) && (busy === 1'b0) && (done === 1'b0);
      @(posedge clk); #1;
      done_cyc = -1;
      for (int c = 1; c <= 40; c++) begin
         start = 1'($urandom()); Funct3 = 3'($urandom()); SrcA = $urandom(); SrcB = $urandom();
         @(negedge clk);
         if (done === 1'b1) begin
            start    = 1'b0;
            done_cyc = c;
            res      = Result;
            if (stall !== 1'b0 || busy !== 1'b1) tim_ok = 1'b0;
            break;
         end
         if (stall !== 1'b1 || busy !== 1'b1) tim_ok = 1'b0;
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (done_cyc > 0) begin
         @(posedge clk); #1;
      end
   endtask

   logic [31:0] res, last_res, exp;
   int          dcyc;
   bit          tok, saw_done;

   initial begin
      reset = 1'b1; start = 1'b0; flush = 1'b0; Funct3 = '0; SrcA = '0; SrcB = '0;

      vq.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
      vq.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
      vq.push_back('{3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
      vq.push_back('{3'd2, 32'h8000_0000,  32'h8000_0000, 32'hC000_0000});
      vq.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
      vq.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
      vq.push_back('{3'd5, 32'd100,        32'd7,         32'd14});
      vq.push_back('{3'd7, 32'd100,        32'd7,         32'd2});
      vq.push_back('{3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF});
      vq.push_back('{3'd6, 32'h1234,       32'd0,         32'h1234});
      vq.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
      vq.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0});
      vq.push_back('{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0});
      vq.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
      vq.push_back('{3'd4, 32'h1234,       32'd0,         32'hFFFF_FFFF});
      vq.push_back('{3'd7, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9});
      vq.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD});
      vq.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1});

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_busy",   32'(busy),  32'd0);
      chk("reset_stall",  32'(stall), 32'd0);
      chk("reset_done",   32'(done),  32'd0);
      chk("reset_result", Result,     32'd0);
      @(posedge clk); #1;

      foreach (vq[i]) begin
         run_op(vq[i].f, vq[i].a, vq[i].b, res, dcyc, tok);
         chk($sformatf("vec%0d_result", i),  res,         vq[i].exp);
         chk($sformatf("vec%0d_latency", i), 32'(dcyc),   32'd33);
         chk($sformatf("vec%0d_timing", i),  32'(tok),    32'd1);
         last_res = vq[i].exp;
      end

      // Flush in BUSY cycle 5: back to IDLE, no done, Result untouched.
      Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd5; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_busy",  32'(busy),  32'd0);
      chk("flush_stall", 32'(stall), 32'd0);
      chk("flush_done",  32'(done),  32'd0);
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      chk("flush_no_done", 32'(saw_done), 32'd0);
      chk("flush_result",  Result,        last_res);
      @(posedge clk); #1;

      // start together with flush in IDLE must not be accepted.
      start = 1'b1; flush = 1'b1;
      @(negedge clk);
      chk("startflush_stall", 32'(stall), 32'd0);
      @(posedge clk); #1 start = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("startflush_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;

      // Reset asserted in cycle 10 of an operation.
      Funct3 = 3'd4; SrcA = 32'hFFFF_0000; SrcB = 32'd3; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("midreset_busy",   32'(busy),  32'd0);
      chk("midreset_stall",  32'(stall), 32'd0);
      chk("midreset_done",   32'(done),  32'd0);
      chk("midreset_result", Result,     32'd0);
      @(posedge clk); #1;
      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, dcyc, tok);
      chk("postreset_result",  res,       32'hFFFF_FFEB);
      chk("postreset_latency", 32'(dcyc), 32'd33);
      chk("postreset_timing",  32'(tok),  32'd1);
      @(negedge clk);
      chk("hold_result", Result, 32'hFFFF_FFEB);
      chk("hold_busy",   32'(busy), 32'd0);
      @(posedge clk); #1;

      for (int k = 0; k < 60; k++) begin
         logic [2:0]  f;
         logic [31:0] a, b;
         f = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         exp = ref_md(f, a, b);
         run_op(f, a, b, res, dcyc, tok);
         chk($sformatf("rand%0d_f%0d_%h_%h", k, f, a, b), res, exp);
         chk($sformatf("rand%0d_latency", k), 32'(dcyc), 32'd33);
         chk($sformatf("rand%0d_timing", k),  32'(tok),  32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
